// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared state encoding, word layout and defaults for the LCD picture scheduler
package lcd_pkg;

    // default width of the word index and of each per-source length field
    localparam int IDXW_DEFAULT = 10;

    // ROM word layout: [8:1] byte, [0] D/C flag (0 = command, 1 = data)
    localparam int WORD_W   = 9;
    localparam int DC_BIT   = 0;
    localparam int BYTE_LSB = 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_SEND = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // width of a source index; never zero so a single-source build still has a pointer
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lcd_rr_arb.sv
// rtl/lcd_rr_arb.sv - round-robin selector: first requester after the pointer, wrapping
module lcd_rr_arb
    import lcd_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int PW    = ptr_w(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_SRC-1:0] gnt,
    output logic [PW-1:0]    gnt_idx
);

    logic          found;
    int            k;
    logic [PW-1:0] kk;

    // scan ptr+1, ptr+2, ... wrapping to 0; the pointer itself is visited last
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        k       = 0;
        kk      = '0;
        for (int i = 1; i <= N_SRC; i++) begin
            k = int'(ptr) + i;
            if (k >= N_SRC) begin
                k = k - N_SRC;
            end
            kk = PW'(k);
            if (!found && req[kk]) begin
                found   = 1'b1;
                gnt[kk] = 1'b1;
                gnt_idx = kk;
            end
        end
    end

endmodule

// File: rtl/lcd_pic_sched.sv
// rtl/lcd_pic_sched.sv - round-robin scheduler streaming picture ROMs into a single LCD writer
module lcd_pic_sched
    import lcd_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int IDXW  = IDXW_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_SRC-1:0]        req_i,
    input  logic [WORD_W*N_SRC-1:0] d_i,
    input  logic [IDXW*N_SRC-1:0]   length_i,
    output logic [N_SRC-1:0]        sync_o,
    output logic [N_SRC-1:0]        en_o,
    output logic                    wr_o,
    output logic [7:0]              wr_d_o,
    output logic                    wr_dc_o,
    input  logic                    wr_busy_i,
    output logic [N_SRC-1:0]        gnt_o,
    output logic [N_SRC-1:0]        done_o,
    output logic                    busy_o
);

    localparam int PW = ptr_w(N_SRC);

    state_t            state, state_nxt;
    logic [PW-1:0]     sel, sel_nxt;
    logic [PW-1:0]     rr_ptr, rr_nxt;
    logic [IDXW-1:0]   idx, idx_nxt;
    logic [IDXW-1:0]   len, len_nxt;

    logic [N_SRC-1:0]  sync_nxt, en_nxt, gnt_nxt, done_nxt;
    logic              wr_nxt, wr_dc_nxt, busy_nxt;
    logic [7:0]        wr_d_nxt;

    logic [N_SRC-1:0]  arb_gnt;
    logic [PW-1:0]     arb_idx;
    logic [WORD_W-1:0] sel_word;
    logic [IDXW-1:0]   sel_len;

    lcd_rr_arb #(
        .N_SRC (N_SRC),
        .PW    (PW)
    ) u_arb (
        .req     (req_i),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    assign sel_word = d_i[int'(sel)*WORD_W +: WORD_W];
    assign sel_len  = length_i[int'(sel)*IDXW +: IDXW];

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state plus next value of every registered output; strobes default low, en_o high
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        rr_nxt    = rr_ptr;
        idx_nxt   = idx;
        len_nxt   = len;
        gnt_nxt   = gnt_o;
        sync_nxt  = '0;
        en_nxt    = '1;
        wr_nxt    = 1'b0;
        wr_d_nxt  = wr_d_o;
        wr_dc_nxt = wr_dc_o;
        done_nxt  = '0;
        case (state)
            ST_IDLE: begin
                if (|req_i) begin
                    sel_nxt   = arb_idx;
                    gnt_nxt   = arb_gnt;
                    sync_nxt  = arb_gnt;
                    state_nxt = ST_SYNC;
                end
            end
            ST_SYNC: begin
                idx_nxt   = '0;
                len_nxt   = sel_len;
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (!wr_busy_i) begin
                    wr_nxt    = 1'b1;
                    wr_d_nxt  = sel_word[BYTE_LSB +: 8];
                    wr_dc_nxt = sel_word[DC_BIT];
                    if (idx != len) begin
                        // gnt_o is the one-hot of sel, so this advances only the granted ROM
                        en_nxt    = ~gnt_o;
                        idx_nxt   = idx + 1'b1;
                        state_nxt = ST_GAP;
                    end else begin
                        // done lands in the DONE cycle, alongside the last write strobe
                        done_nxt  = gnt_o;
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_GAP: begin
                state_nxt = ST_SEND;
            end
            ST_DONE: begin
                gnt_nxt   = '0;
                rr_nxt    = sel;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        busy_nxt = (state_nxt != ST_IDLE);
    end

    // datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel     <= '0;
            rr_ptr  <= PW'(N_SRC - 1);
            idx     <= '0;
            len     <= '0;
            gnt_o   <= '0;
            sync_o  <= '0;
            en_o    <= '1;
            wr_o    <= 1'b0;
            wr_d_o  <= 8'h00;
            wr_dc_o <= 1'b0;
            done_o  <= '0;
            busy_o  <= 1'b0;
        end else begin
            sel     <= sel_nxt;
            rr_ptr  <= rr_nxt;
            idx     <= idx_nxt;
            len     <= len_nxt;
            gnt_o   <= gnt_nxt;
            sync_o  <= sync_nxt;
            en_o    <= en_nxt;
            wr_o    <= wr_nxt;
            wr_d_o  <= wr_d_nxt;
            wr_dc_o <= wr_dc_nxt;
            done_o  <= done_nxt;
            busy_o  <= busy_nxt;
        end
    end

endmodule
